tqvp_pwm_fade: RTL and testbench



---
 rtl/tqvp_pwm_fade.sv | 157 +++++++++++++++
 tb/tb_tqvp_pwm_fade.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tqvp_pwm_fade.sv
// Duty-cycle fade engine: ramps duty_out toward a programmed target in
// saturating steps spaced PRESCALE+1 cycles apart, with busy/done status
// and a one-cycle completion pulse.
module tqvp_pwm_fade #(
    parameter logic [7:0] DEFAULT_STEP = 8'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic [7:0] duty_out,
    output logic       busy,
    output logic       done_pulse
);

    typedef enum logic [0:0] {IDLE = 1'b0, RAMP = 1'b1} state_t;

    localparam logic [3:0] ADDR_TARGET   = 4'h0;
    localparam logic [3:0] ADDR_STEP     = 4'h1;
    localparam logic [3:0] ADDR_PRESCALE = 4'h2;
    localparam logic [3:0] ADDR_CURRENT  = 4'h3;
    localparam logic [3:0] ADDR_STATUS   = 4'h4;

    state_t     state, state_n;
    logic [7:0] target, target_n;
    logic [7:0] step, step_n;
    logic [7:0] prescale, prescale_n;
    logic [7:0] current, current_n;
    logic [7:0] cnt, cnt_n;
    logic       done, done_n;
    logic       pulse_n;

    logic       wr_target, wr_step, wr_prescale, wr_current, wr_status;
    logic       done_set;
    logic [7:0] stepped;

    // One saturating step from cur toward tgt; the extra headroom bits mean
    // neither direction can wrap before the clamp is applied.
    function automatic logic [7:0] sat_step(input logic [7:0] cur,
                                            input logic [7:0] tgt,
                                            input logic [7:0] stp);
        logic signed [9:0] c;
        logic signed [9:0] t;
        logic signed [9:0] s;
        logic signed [9:0] r;
        c = signed'({2'b00, cur});
        t = signed'({2'b00, tgt});
        s = signed'({2'b00, stp});
        if (stp == 8'd0) begin
            r = t;
        end else if (c < t) begin
            r = c + s;
            if (r > t) r = t;
        end else begin
            r = c - s;
            if (r < t) r = t;
        end
        return r[7:0];
    endfunction

    assign wr_target   = data_write && (address == ADDR_TARGET);
    assign wr_step     = data_write && (address == ADDR_STEP);
    assign wr_prescale = data_write && (address == ADDR_PRESCALE);
    assign wr_current  = data_write && (address == ADDR_CURRENT);
    assign wr_status   = data_write && (address == ADDR_STATUS);

    assign stepped = sat_step(current, target, step);

    // Next-state and register-update logic; a CURRENT write overrides any step.
    always_comb begin
        state_n    = state;
        target_n   = target;
        step_n     = step;
        prescale_n = prescale;
        current_n  = current;
        cnt_n      = cnt;
        done_set   = 1'b0;
        pulse_n    = 1'b0;

        if (wr_step)     step_n     = data_in;
        if (wr_prescale) prescale_n = data_in;

        if (wr_current) begin
            current_n = data_in;
            state_n   = IDLE;
        end else if (wr_target) begin
            target_n = data_in;
            cnt_n    = prescale;
            if (data_in == current) begin
                state_n  = IDLE;
                done_set = 1'b1;
                pulse_n  = 1'b1;
            end else begin
                state_n = RAMP;
            end
        end else if (state == RAMP) begin
            if (cnt != 8'd0) begin
                cnt_n = cnt - 8'd1;
            end else begin
                current_n = stepped;
                cnt_n     = prescale;
                if (stepped == target) begin
                    state_n  = IDLE;
                    done_set = 1'b1;
                    pulse_n  = 1'b1;
                end
            end
        end

        // A clear on the same edge as a completion loses to the set.
        done_n = done;
        if (wr_status && data_in[1]) done_n = 1'b0;
        if (done_set)                done_n = 1'b1;
    end

    // State and register file, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            target     <= 8'd0;
            step       <= DEFAULT_STEP;
            prescale   <= 8'd0;
            current    <= 8'd0;
            cnt        <= 8'd0;
            done       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            target     <= target_n;
            step       <= step_n;
            prescale   <= prescale_n;
            current    <= current_n;
            cnt        <= cnt_n;
            done       <= done_n;
            done_pulse <= pulse_n;
        end
    end

    assign duty_out = current;
    assign busy     = (state == RAMP);

    // Zero-latency register read mux.
    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_TARGET:   data_out = target;
            ADDR_STEP:     data_out = step;
            ADDR_PRESCALE: data_out = prescale;
            ADDR_CURRENT:  data_out = current;
            ADDR_STATUS:   data_out = {6'b0, done, busy};
            default:       data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tqvp_pwm_fade.sv
// Table-driven bench for tqvp_pwm_fade: each record is one clock cycle of
// bus activity plus the outputs expected just after that edge.
module tb_tqvp_pwm_fade;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [7:0] duty_out;
    logic       busy;
    logic       done_pulse;

    int checks = 0;
    int errors = 0;

    tqvp_pwm_fade #(.DEFAULT_STEP(8'd1)) dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out),
        .duty_out   (duty_out),
        .busy       (busy),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         wr;
        logic [3:0] addr;
        logic [7:0] din;
        logic [7:0] e_duty;
        bit         e_busy;
        bit         e_pulse;
        logic [7:0] e_rd;
    } vec_t;

    vec_t vq[$];

    function automatic void v(bit wr, logic [3:0] a, logic [7:0] d,
                              logic [7:0] duty, bit b, bit p, logic [7:0] rd);
        vec_t r;
        r.wr = wr; r.addr = a; r.din = d;
        r.e_duty = duty; r.e_busy = b; r.e_pulse = p; r.e_rd = rd;
        vq.push_back(r);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] dn[5];
    logic [7:0] lvl;

    initial begin
        rst = 1'b1; address = 4'h0; data_write = 1'b0; data_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_duty", duty_out, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_pulse", {7'b0, done_pulse}, 8'h00);
        address = 4'h1; #1;
        chk("rst_step_rd", data_out, 8'h01);
        address = 4'h4; #1;
        chk("rst_status_rd", data_out, 8'h00);
        rst = 1'b0;

        // Up ramp: STEP 0x10, PRESCALE 3, TARGET 0x40
        v(1, 4'h1, 8'h10, 8'h00, 0, 0, 8'h10);
        v(1, 4'h2, 8'h03, 8'h00, 0, 0, 8'h03);
        v(1, 4'h0, 8'h40, 8'h00, 1, 0, 8'h40);
        for (int k = 1; k <= 16; k++) begin
            lvl = 8'(16 * (k / 4));
            v(0, 4'h3, 8'h00, lvl, k != 16, k == 16, lvl);
        end
        v(0, 4'h4, 8'h00, 8'h40, 0, 0, 8'h02);
        v(1, 4'h4, 8'h02, 8'h40, 0, 0, 8'h00);

        // Down ramp with clamp at the target
        dn[0] = 8'hC0; dn[1] = 8'h90; dn[2] = 8'h60; dn[3] = 8'h30; dn[4] = 8'h05;
        v(1, 4'h3, 8'hF0, 8'hF0, 0, 0, 8'hF0);
        v(1, 4'h1, 8'h30, 8'hF0, 0, 0, 8'h30);
        v(1, 4'h2, 8'h00, 8'hF0, 0, 0, 8'h00);
        v(1, 4'h0, 8'h05, 8'hF0, 1, 0, 8'h05);
        for (int i = 0; i < 5; i++) v(0, 4'h3, 8'h00, dn[i], i != 4, i == 4, dn[i]);
        v(0, 4'h4, 8'h00, 8'h05, 0, 0, 8'h02);

        // Target equal to current; done clear; unmapped address
        v(1, 4'h4, 8'h02, 8'h05, 0, 0, 8'h00);
        v(1, 4'h0, 8'h05, 8'h05, 0, 1, 8'h05);
        v(0, 4'h4, 8'h00, 8'h05, 0, 0, 8'h02);
        v(1, 4'h4, 8'h02, 8'h05, 0, 0, 8'h00);
        v(1, 4'h9, 8'hAA, 8'h05, 0, 0, 8'h00);
        v(0, 4'h9, 8'h00, 8'h05, 0, 0, 8'h00);

        // STEP 0 with PRESCALE 2 jumps on the third edge
        v(1, 4'h1, 8'h00, 8'h05, 0, 0, 8'h00);
        v(1, 4'h2, 8'h02, 8'h05, 0, 0, 8'h02);
        v(1, 4'h0, 8'h77, 8'h05, 1, 0, 8'h77);
        v(0, 4'h3, 8'h00, 8'h05, 1, 0, 8'h05);
        v(0, 4'h3, 8'h00, 8'h05, 1, 0, 8'h05);
        v(0, 4'h3, 8'h00, 8'h77, 0, 1, 8'h77);
        v(0, 4'h3, 8'h00, 8'h77, 0, 0, 8'h77);

        // Retarget mid-ramp: up toward 0xFF, reverse at 0x20 down to 0x10
        v(1, 4'h1, 8'h01, 8'h77, 0, 0, 8'h01);
        v(1, 4'h2, 8'h00, 8'h77, 0, 0, 8'h00);
        v(1, 4'h3, 8'h00, 8'h00, 0, 0, 8'h00);
        v(1, 4'h0, 8'hFF, 8'h00, 1, 0, 8'hFF);
        for (int k = 1; k <= 32; k++) v(0, 4'h3, 8'h00, 8'(k), 1, 0, 8'(k));
        v(1, 4'h0, 8'h10, 8'h20, 1, 0, 8'h10);
        for (int k = 1; k <= 16; k++) begin
            lvl = 8'(32 - k);
            v(0, 4'h3, 8'h00, lvl, k != 16, k == 16, lvl);
        end
        v(0, 4'h4, 8'h00, 8'h10, 0, 0, 8'h02);

        // Abort with a CURRENT write on an edge that would also step
        v(1, 4'h4, 8'h02, 8'h10, 0, 0, 8'h00);
        v(1, 4'h0, 8'h40, 8'h10, 1, 0, 8'h40);
        v(0, 4'h3, 8'h00, 8'h11, 1, 0, 8'h11);
        v(0, 4'h3, 8'h00, 8'h12, 1, 0, 8'h12);
        v(1, 4'h3, 8'h80, 8'h80, 0, 0, 8'h80);
        v(0, 4'h4, 8'h00, 8'h80, 0, 0, 8'h00);

        // Done clear on the same edge as completion: set wins
        v(1, 4'h0, 8'h81, 8'h80, 1, 0, 8'h81);
        v(1, 4'h4, 8'h02, 8'h81, 0, 1, 8'h02);
        v(0, 4'h4, 8'h00, 8'h81, 0, 0, 8'h02);

        foreach (vq[i]) begin
            data_write = vq[i].wr;
            address    = vq[i].addr;
            data_in    = vq[i].din;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_duty", i), duty_out, vq[i].e_duty);
            chk($sformatf("v%0d_busy", i), {7'b0, busy}, {7'b0, vq[i].e_busy});
            chk($sformatf("v%0d_pulse", i), {7'b0, done_pulse}, {7'b0, vq[i].e_pulse});
            chk($sformatf("v%0d_rd", i), data_out, vq[i].e_rd);
        end

        // Asynchronous reset mid-ramp at CURRENT 0x40
        data_write = 1'b1; address = 4'h3; data_in = 8'h00; @(posedge clk); #1;
        address = 4'h1; data_in = 8'h20; @(posedge clk); #1;
        address = 4'h0; data_in = 8'hFF; @(posedge clk); #1;
        data_write = 1'b0; address = 4'h3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_duty", duty_out, 8'h40);
        chk("mid_busy", {7'b0, busy}, 8'h01);
        #2 rst = 1'b1;
        #1;
        chk("arst_duty", duty_out, 8'h00);
        chk("arst_busy", {7'b0, busy}, 8'h00);
        chk("arst_pulse", {7'b0, done_pulse}, 8'h00);
        address = 4'h4; #1;
        chk("arst_status", data_out, 8'h00);
        address = 4'h1; #1;
        chk("arst_step", data_out, 8'h01);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", {7'b0, busy}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
